// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller: stall patterns,
// stall bit indices, FSM state encoding and the default exception vector.
package pipeline_hazard_ctrl_pkg;

   localparam int STALL_W = 6;

   localparam logic [STALL_W-1:0] STALL_NONE    = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_LOADUSE = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_MC      = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM     = 6'b011111;

   // stall_o bit positions: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, WB
   localparam int STALL_PC    = 0;
   localparam int STALL_IF_ID = 1;
   localparam int STALL_ID_EX = 2;
   localparam int STALL_EX_MM = 3;
   localparam int STALL_MM_WB = 4;
   localparam int STALL_WB    = 5;

   localparam logic [31:0] EXC_VECTOR_DEF = 32'hBFC00380;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } hz_state_e;

   // True when an enabled ID source register matches the EX destination.
   function automatic logic src_hit(input logic       en,
                                    input logic [4:0] addr,
                                    input logic [4:0] wa);
      return en && (addr == wa);
   endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mc_stall_timer.sv
// Loadable down-counter timing the remaining cycles of a multi-cycle EX op.
// Ports: clk, rst, load_i/load_val_i, dec_i, clear_i in; zero_o out.
module mc_stall_timer
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int CYC_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CYC_W-1:0] load_val_i,
   input  logic             dec_i,
   input  logic             clear_i,
   output logic             zero_o
);

   logic [CYC_W-1:0] cnt_q;
   logic [CYC_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - CYC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer: load-use, multi-cycle EX ops, memory wait
// and exception flush. Ports: ID/EX hazard inputs, mem_busy_i, ex_excp_i in;
// stall_o, flush_o, newPc_o, mc_done_o, stallCycles_o out.
module pipeline_hazard_ctrl
   import pipeline_hazard_ctrl_pkg::*;
#(
   parameter int          CYC_W      = 5,
   parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_readEnable1_i,
   input  logic [4:0]         id_readAddr1_i,
   input  logic               id_readEnable2_i,
   input  logic [4:0]         id_readAddr2_i,
   input  logic               ex_isLoad_i,
   input  logic [4:0]         ex_writeAddr_i,
   input  logic               ex_mcStart_i,
   input  logic [CYC_W-1:0]   ex_mcCycles_i,
   input  logic               mem_busy_i,
   input  logic               ex_excp_i,
   output logic [STALL_W-1:0] stall_o,
   output logic               flush_o,
   output logic [31:0]        newPc_o,
   output logic               mc_done_o,
   output logic [31:0]        stallCycles_o
);

   hz_state_e   state_q, state_d;
   logic [31:0] stall_cnt_q;

   logic             load_use;
   logic             mc_go;
   logic             tm_load, tm_dec, tm_clear, tm_zero;
   logic [CYC_W-1:0] tm_val;

   assign load_use = ex_isLoad_i && (ex_writeAddr_i != 5'd0) &&
      (src_hit(id_readEnable1_i, id_readAddr1_i, ex_writeAddr_i) ||
       src_hit(id_readEnable2_i, id_readAddr2_i, ex_writeAddr_i));

   assign mc_go = (state_q == ST_RUN) && ex_mcStart_i &&
                  (ex_mcCycles_i != '0);

   // The start cycle already counts as the first stall cycle, so MC_WAIT
   // must cover N-1 more cycles: the timer is loaded with N-2 and the
   // cycle that sees it at zero is the last one. N==1 finishes in the
   // start cycle itself.
   assign tm_val = ex_mcCycles_i - CYC_W'(2);

   always_comb begin
      state_d   = state_q;
      stall_o   = STALL_NONE;
      flush_o   = 1'b0;
      mc_done_o = 1'b0;
      tm_load   = 1'b0;
      tm_dec    = 1'b0;
      tm_clear  = 1'b0;

      unique case (state_q)
         ST_FLUSH: begin
            flush_o = 1'b1;
            state_d = ST_RUN;
         end
         ST_MC_WAIT: begin
            stall_o = STALL_MC;
            if (tm_zero) begin
               mc_done_o = 1'b1;
               state_d   = ST_RUN;
            end else begin
               tm_dec = 1'b1;
            end
         end
         default: begin
            if (mc_go) begin
               stall_o = STALL_MC;
               if (ex_mcCycles_i == CYC_W'(1)) begin
                  mc_done_o = 1'b1;
               end else begin
                  tm_load = 1'b1;
                  state_d = ST_MC_WAIT;
               end
            end
         end
      endcase

      if (state_q != ST_FLUSH) begin
         if (load_use)   stall_o = stall_o | STALL_LOADUSE;
         if (mem_busy_i) stall_o = stall_o | STALL_MEM;
      end

      // Exception overrides everything: no stall, abort any op silently.
      if (ex_excp_i) begin
         stall_o   = STALL_NONE;
         mc_done_o = 1'b0;
         tm_load   = 1'b0;
         tm_dec    = 1'b0;
         tm_clear  = 1'b1;
         state_d   = ST_FLUSH;
      end
   end

   assign newPc_o       = flush_o ? EXC_VECTOR : 32'd0;
   assign stallCycles_o = stall_cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_RUN;
         stall_cnt_q <= 32'd0;
      end else begin
         state_q <= state_d;
         if (stall_o[STALL_PC] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   mc_stall_timer #(
      .CYC_W(CYC_W)
   ) u_timer (
      .clk       (clk),
      .rst       (rst),
      .load_i    (tm_load),
      .load_val_i(tm_val),
      .dec_i     (tm_dec),
      .clear_i   (tm_clear),
      .zero_o    (tm_zero)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, expected outputs from a cycle-count reference model.
module tb_pipeline_hazard_ctrl;

   localparam logic [31:0] EXC = 32'hBFC00380;

   logic        clk = 1'b0;
   logic        rst;
   logic        en1, en2, ld, st, busy, ex;
   logic [4:0]  a1, a2, wa, n;
   logic [5:0]  stall;
   logic        flush, done;
   logic [31:0] npc, scyc;

   typedef struct packed {
      logic       r;
      logic       en1;
      logic [4:0] a1;
      logic       en2;
      logic [4:0] a2;
      logic       ld;
      logic [4:0] wa;
      logic       st;
      logic [4:0] n;
      logic       busy;
      logic       ex;
   } stim_t;

   typedef struct {
      logic [5:0]  stall;
      logic        flush;
      logic [31:0] pc;
      logic        done;
      logic [31:0] cnt;
      string       tag;
   } exp_t;

   exp_t q[$];

   int     vectors = 0;
   int     miscompares = 0;

   // reference model: remaining stall cycles of the active op
   int     mc_left = 0;
   bit     in_flush = 0;
   longint scnt = 0;

   pipeline_hazard_ctrl dut (
      .clk             (clk),
      .rst             (rst),
      .id_readEnable1_i(en1),
      .id_readAddr1_i  (a1),
      .id_readEnable2_i(en2),
      .id_readAddr2_i  (a2),
      .ex_isLoad_i     (ld),
      .ex_writeAddr_i  (wa),
      .ex_mcStart_i    (st),
      .ex_mcCycles_i   (n),
      .mem_busy_i      (busy),
      .ex_excp_i       (ex),
      .stall_o         (stall),
      .flush_o         (flush),
      .newPc_o         (npc),
      .mc_done_o       (done),
      .stallCycles_o   (scyc)
   );

   always #5 clk = ~clk;

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic apply(input stim_t s, input string tag);
      exp_t e;
      bit   lu, nf;
      int   nm;
      @(posedge clk);
      #1;
      rst = s.r; en1 = s.en1; a1 = s.a1; en2 = s.en2; a2 = s.a2;
      ld = s.ld; wa = s.wa; st = s.st; n = s.n; busy = s.busy;
      ex = s.ex;
      lu = s.ld && (s.wa != 0) &&
           ((s.en1 && s.a1 == s.wa) || (s.en2 && s.a2 == s.wa));
      e.stall = 6'd0; e.flush = 0; e.pc = 0; e.done = 0;
      e.cnt = scnt[31:0]; e.tag = tag;
      nm = 0; nf = 0;
      if (in_flush) begin
         e.flush = 1; e.pc = EXC; nf = s.ex;
      end else if (s.ex) begin
         nf = 1;
      end else begin
         if (mc_left > 0) begin
            e.stall = 6'b001111;
            e.done = (mc_left == 1);
            nm = mc_left - 1;
         end else if (s.st && s.n != 0) begin
            e.stall = 6'b001111;
            e.done = (s.n == 1);
            nm = int'(s.n) - 1;
         end
         if (lu)     e.stall = e.stall | 6'b000111;
         if (s.busy) e.stall = e.stall | 6'b011111;
      end
      q.push_back(e);
      if (s.r) begin
         mc_left = 0; in_flush = 0; scnt = 0;
      end else begin
         mc_left = nm; in_flush = nf;
         if (e.stall[0] && scnt < 64'hFFFF_FFFF) scnt++;
      end
   endtask

   task automatic quiet(input int k, input string tag);
      for (int i = 0; i < k; i++) apply(idle(), tag);
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (stall !== e.stall || flush !== e.flush || npc !== e.pc ||
             done !== e.done || scyc !== e.cnt) begin
            miscompares++;
            $display("FAIL %s @%0t: got stall=%b flush=%b pc=%h done=%b cnt=%0d, want stall=%b flush=%b pc=%h done=%b cnt=%0d",
               e.tag, $time, stall, flush, npc, done, scyc,
               e.stall, e.flush, e.pc, e.done, e.cnt);
         end
      end
   end

   initial begin
      stim_t s;
      rst = 1; en1 = 0; en2 = 0; a1 = 0; a2 = 0; ld = 0; wa = 0;
      st = 0; n = 0; busy = 0; ex = 0;
      repeat (2) @(posedge clk);
      #1 rst = 0;

      quiet(1, "reset");

      s = idle(); s.ld = 1; s.wa = 5; s.en1 = 1; s.a1 = 5;
      apply(s, "loaduse");
      quiet(1, "loaduse_after");
      s.wa = 0; s.a1 = 0;
      apply(s, "loaduse_r0");
      s = idle(); s.ld = 1; s.wa = 9; s.en2 = 1; s.a2 = 9;
      apply(s, "loaduse_rt");

      s = idle(); s.st = 1; s.n = 4;
      apply(s, "mc4");
      quiet(4, "mc4_wait");

      s = idle(); s.st = 1; s.n = 6;
      apply(s, "mc6");
      quiet(1, "mc6_wait");
      s = idle(); s.busy = 1;
      apply(s, "mc6_busy");
      quiet(4, "mc6_wait");

      s = idle(); s.st = 1; s.n = 8;
      apply(s, "mc8");
      quiet(1, "mc8_wait");
      s = idle(); s.ex = 1;
      apply(s, "mc8_excp");
      quiet(3, "mc8_flush");

      s = idle(); s.ex = 1;
      apply(s, "excp");
      apply(s, "excp_again");
      quiet(2, "excp_after");

      s = idle(); s.ld = 1; s.wa = 3; s.en1 = 1; s.a1 = 3; s.busy = 1;
      apply(s, "lu_busy");
      s = idle(); s.st = 1; s.n = 0;
      apply(s, "mc0");
      s = idle(); s.st = 1; s.n = 31;
      apply(s, "mc31");
      quiet(32, "mc31_wait");

      s = idle(); s.st = 1; s.n = 10;
      apply(s, "mc10");
      quiet(2, "mc10_wait");
      s = idle(); s.r = 1;
      apply(s, "mc10_rst");
      quiet(2, "after_rst");

      for (int i = 0; i < 3000; i++) begin
         s.r    = ($urandom_range(0, 149) == 0);
         s.en1  = 1'($urandom_range(0, 1));
         s.a1   = 5'($urandom_range(0, 3));
         s.en2  = 1'($urandom_range(0, 1));
         s.a2   = 5'($urandom_range(0, 3));
         s.ld   = ($urandom_range(0, 2) == 0);
         s.wa   = 5'($urandom_range(0, 3));
         s.st   = ($urandom_range(0, 4) == 0);
         s.n    = 5'($urandom_range(0, 12));
         s.busy = ($urandom_range(0, 5) == 0);
         s.ex   = ($urandom_range(0, 39) == 0);
         apply(s, "random");
      end

      quiet(1, "drain");
      repeat (3) @(posedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==",
         vectors, miscompares);
      $finish;
   end

endmodule
